uart_rx_oversampled: RTL and testbench

Serial UART receiver that recovers 8N1 or 8E1/8O1 frames from the asynchronous `rx` line, using the one-cycle `os_tick` strobe from the oversampling clock generator as its sampling time base. It sits between the pad-side RX pin and the byte-level consumer. It is the receive-side counterpart of the oversampled baud timing path and shares that path's `oversampling_factor` setting.

---
 rtl/uart_rx_oversampled.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: recovers LSB-first frames with optional even/odd parity
// using the os_tick strobe as the sampling time base.
module uart_rx_oversampled #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 os_tick,
   input  logic [4:0]           oversampling_factor,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_error,
   output logic                 frame_error,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic       ODD_PAR  = (PARITY == 2);

   function automatic logic [4:0] sat_factor(input logic [4:0] f);
      return (f < 5'd4) ? 5'd4 : f;
   endfunction

   function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
      return (^d) ^ p ^ ODD_PAR;
   endfunction

   state_t               state, state_nxt;
   logic                 rx_meta_p0, rx_s;
   logic [4:0]           f_lat, f_nxt, tick_cnt, tick_nxt, half;
   logic [2:0]           bit_idx, idx_nxt;
   logic [DATA_BITS-1:0] shift_p1;
   logic                 par_bad, par_bad_nxt;
   logic                 shift_en, valid_nxt, perr_nxt, ferr_nxt;
   logic                 at_half, at_full;

   assign half    = f_lat >> 1;
   assign at_half = (tick_cnt == half - 5'd1);
   assign at_full = (tick_cnt == f_lat - 5'd1);
   assign busy    = (state != S_IDLE);

   // Stage p0: two-flop synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_meta_p0 <= rx;
         rx_s       <= rx_meta_p0;
      end
   end

   always_comb begin
      state_nxt   = state;
      f_nxt       = f_lat;
      tick_nxt    = tick_cnt;
      idx_nxt     = bit_idx;
      par_bad_nxt = par_bad;
      shift_en    = 1'b0;
      valid_nxt   = 1'b0;
      perr_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      if (os_tick) begin
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state_nxt = S_START;
                  tick_nxt  = 5'd0;
                  f_nxt     = sat_factor(oversampling_factor);
               end
            end
            S_START: begin
               if (at_half) begin
                  tick_nxt  = 5'd0;
                  idx_nxt   = 3'd0;
                  state_nxt = rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_nxt = tick_cnt + 5'd1;
               end
            end
            S_DATA: begin
               if (at_full) begin
                  shift_en = 1'b1;
                  tick_nxt = 5'd0;
                  idx_nxt  = bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT)
                     state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  tick_nxt = tick_cnt + 5'd1;
               end
            end
            S_PARITY: begin
               if (at_full) begin
                  // All data bits are in the shift register by now
                  par_bad_nxt = parity_mismatch(shift_p1, rx_s);
                  tick_nxt    = 5'd0;
                  state_nxt   = S_STOP;
               end else begin
                  tick_nxt = tick_cnt + 5'd1;
               end
            end
            S_STOP: begin
               if (at_full) begin
                  tick_nxt = 5'd0;
                  if (rx_s) begin
                     valid_nxt = 1'b1;
                     perr_nxt  = par_bad;
                     state_nxt = S_IDLE;
                  end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = S_BREAK;
                  end
               end else begin
                  tick_nxt = tick_cnt + 5'd1;
               end
            end
            S_BREAK: begin
               if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Stage p1: frame control and registered output pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         f_lat        <= 5'd0;
         tick_cnt     <= 5'd0;
         bit_idx      <= 3'd0;
         par_bad      <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         state        <= state_nxt;
         f_lat        <= f_nxt;
         tick_cnt     <= tick_nxt;
         bit_idx      <= idx_nxt;
         par_bad      <= par_bad_nxt;
         rx_valid     <= valid_nxt;
         parity_error <= perr_nxt;
         frame_error  <= ferr_nxt;
         if (valid_nxt) rx_data <= shift_p1;
      end
   end

   // Payload shift register is fully overwritten every frame before use
   always_ff @(posedge clk) begin
      if (shift_en) shift_p1 <= {rx_s, shift_p1[DATA_BITS-1:1]};
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: three receivers (no/even/odd parity) checked every
// cycle against a tick-counting frame model, plus literal checks on decoded frames.
module tb_uart_rx_oversampled;
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       os_tick = 1'b0;
   logic [4:0] factor;
   logic       rx_l [N];
   int         tick_mode = 0;
   int         checks = 0;
   int         errors = 0;

   logic [7:0]  d_data [N];
   logic        d_valid [N], d_perr [N], d_ferr [N], d_busy [N];
   logic [7:0]  e_data_w [N];
   logic        e_valid_w [N], e_perr_w [N], e_ferr_w [N], e_busy_w [N];
   logic [31:0] n_valid_w [N], n_perr_w [N], n_ferr_w [N], busy_len_w [N];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_mode == 0) os_tick = 1'b1;
      else                os_tick = ($urandom_range(0, tick_mode) == 0);
   end

   function automatic int clampf(input logic [4:0] f);
      return (f < 5'd4) ? 4 : int'(f);
   endfunction

   genvar g;
   for (g = 0; g < N; g++) begin : inst
      uart_rx_oversampled #(.DATA_BITS(8), .PARITY(g)) dut (
         .clk                 (clk),
         .rst                 (rst),
         .os_tick             (os_tick),
         .oversampling_factor (factor),
         .rx                  (rx_l[g]),
         .rx_data             (d_data[g]),
         .rx_valid            (d_valid[g]),
         .parity_error        (d_perr[g]),
         .frame_error         (d_ferr[g]),
         .busy                (d_busy[g])
      );

      logic [7:0] e_data = 8'h00;
      logic e_valid = 1'b0, e_perr = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;
      logic s1 = 1'b1, s2 = 1'b1;
      bit   abort = 1'b0;
      int   nv = 0, np = 0, nf = 0, blen = 0, fcur = 4;

      assign e_data_w[g]   = e_data;
      assign e_valid_w[g]  = e_valid;
      assign e_perr_w[g]   = e_perr;
      assign e_ferr_w[g]   = e_ferr;
      assign e_busy_w[g]   = e_busy;
      assign n_valid_w[g]  = nv;
      assign n_perr_w[g]   = np;
      assign n_ferr_w[g]   = nf;
      assign busy_len_w[g] = blen;

      // One clock edge: returns whether it was a tick and the line value the receiver sees
      task automatic step(output bit t, output logic s);
         @(posedge clk);
         if (e_busy) blen++;
         e_valid = 1'b0; e_perr = 1'b0; e_ferr = 1'b0;
         if (!rst) begin
            e_data = 8'h00; e_busy = 1'b0; s1 = 1'b1; s2 = 1'b1;
            abort = 1'b1; t = 1'b0; s = 1'b1;
         end else begin
            t = os_tick; s = s2; s2 = s1; s1 = rx_l[g];
            fcur = clampf(factor);
         end
      endtask

      task automatic wait_ticks(input int n, output logic s);
         bit t;
         int c;
         c = 0; s = 1'b1;
         while (c < n) begin
            step(t, s);
            if (abort) return;
            if (t) c++;
         end
      endtask

      task automatic frame();
         bit t;
         logic s, pb, bad;
         logic [7:0] d;
         int f;
         abort = 1'b0;
         do begin
            step(t, s);
            if (abort) return;
         end while (!(t && !s));
         f = fcur;
         e_busy = 1'b1;
         wait_ticks(f / 2, s);
         if (abort) return;
         if (s) begin e_busy = 1'b0; return; end
         for (int b = 0; b < 8; b++) begin
            wait_ticks(f, s);
            if (abort) return;
            d[b] = s;
         end
         bad = 1'b0;
         if (g != 0) begin
            wait_ticks(f, pb);
            if (abort) return;
            bad = (($countones(d) + int'(pb)) % 2) != ((g == 2) ? 1 : 0);
         end
         wait_ticks(f, s);
         if (abort) return;
         if (s) begin
            e_valid = 1'b1; e_data = d; e_perr = bad; e_busy = 1'b0;
            nv++;
            if (bad) np++;
         end else begin
            e_ferr = 1'b1; nf++;
            do begin
               step(t, s);
               if (abort) return;
            end while (!(t && s));
            e_busy = 1'b0;
         end
      endtask

      initial forever frame();
   end

   task automatic chk(input string nm, input int i, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, i, a, e, $time);
      end
   endtask

   task automatic lit(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, a, e);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rx_valid", i, {7'd0, d_valid[i]}, {7'd0, e_valid_w[i]});
         chk("parity_error", i, {7'd0, d_perr[i]}, {7'd0, e_perr_w[i]});
         chk("frame_error", i, {7'd0, d_ferr[i]}, {7'd0, e_ferr_w[i]});
         chk("busy", i, {7'd0, d_busy[i]}, {7'd0, e_busy_w[i]});
         chk("rx_data", i, d_data[i], e_data_w[i]);
      end
   end

   task automatic hold(input int n);
      int c;
      c = 0;
      while (c < n) begin
         @(posedge clk);
         if (os_tick) c++;
      end
      @(negedge clk);
   endtask

   task automatic send(input int i, input logic [7:0] d, input int f, input bit has_par,
                       input logic pb, input logic stop, input int chg_bit, input logic [4:0] chg_val);
      logic [10:0] bits;
      int nb;
      if (has_par) begin bits = {stop, pb, d, 1'b0}; nb = 11; end
      else         begin bits = {1'b1, stop, d, 1'b0}; nb = 10; end
      @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         if (k == chg_bit) factor = chg_val;
         rx_l[i] = bits[k];
         hold(f);
      end
   endtask

   int fl_fast [6] = '{3, 4, 6, 9, 12, 16};
   int fl_slow [4] = '{8, 10, 12, 16};

   initial begin
      int v0, p0, f0, b0, i, f, pbad;
      logic [7:0] d;
      logic pb, st;
      rst = 1'b0; factor = 5'd16; tick_mode = 0;
      for (int k = 0; k < N; k++) rx_l[k] = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      hold(4);

      // 0xA5 8N1 at 16 ticks/bit, one tick per clk
      v0 = n_valid_w[0]; p0 = n_perr_w[0]; f0 = n_ferr_w[0]; b0 = busy_len_w[0];
      send(0, 8'hA5, 16, 1'b0, 1'b0, 1'b1, -1, 5'd0);
      hold(20);
      lit("a5_data", e_data_w[0], 8'hA5);
      lit("a5_valid_cnt", n_valid_w[0] - v0, 1);
      lit("a5_perr_cnt", n_perr_w[0] - p0, 0);
      lit("a5_ferr_cnt", n_ferr_w[0] - f0, 0);
      lit("a5_busy_len", busy_len_w[0] - b0, 152);

      // Short glitch is rejected by the start-bit sample
      v0 = n_valid_w[0]; f0 = n_ferr_w[0];
      rx_l[0] = 1'b0; hold(4); rx_l[0] = 1'b1; hold(30);
      lit("glitch_valid_cnt", n_valid_w[0] - v0, 0);
      lit("glitch_ferr_cnt", n_ferr_w[0] - f0, 0);
      lit("glitch_busy", e_busy_w[0], 0);

      // Stop bit forced low, then line held low (break)
      v0 = n_valid_w[0]; f0 = n_ferr_w[0];
      send(0, 8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, 5'd0);
      hold(30);
      lit("brk_ferr_cnt", n_ferr_w[0] - f0, 1);
      lit("brk_valid_cnt", n_valid_w[0] - v0, 0);
      lit("brk_busy", e_busy_w[0], 1);
      lit("brk_data_kept", e_data_w[0], 8'hA5);
      rx_l[0] = 1'b1; hold(6);
      lit("brk_busy_end", e_busy_w[0], 0);

      // Even parity on instance 1, odd parity on instance 2, data 0x07
      for (int k = 1; k < N; k++) begin
         for (int pv = 0; pv < 2; pv++) begin
            v0 = n_valid_w[k]; p0 = n_perr_w[k];
            send(k, 8'h07, 16, 1'b1, pv[0], 1'b1, -1, 5'd0);
            hold(6);
            lit($sformatf("par%0d_pb%0d_data", k, pv), e_data_w[k], 8'h07);
            lit($sformatf("par%0d_pb%0d_valid", k, pv), n_valid_w[k] - v0, 1);
            lit($sformatf("par%0d_pb%0d_perr", k, pv), n_perr_w[k] - p0, ((k == 1) == (pv == 0)) ? 1 : 0);
         end
      end

      // Factor changed from 16 to 8 during a frame; next frame at 8 ticks/bit
      send(0, 8'hC3, 16, 1'b0, 1'b0, 1'b1, 5, 5'd8);
      hold(4);
      lit("chg_first_data", e_data_w[0], 8'hC3);
      v0 = n_valid_w[0];
      send(0, 8'h81, 8, 1'b0, 1'b0, 1'b1, -1, 5'd0);
      hold(4);
      lit("chg_second_data", e_data_w[0], 8'h81);
      lit("chg_second_valid", n_valid_w[0] - v0, 1);

      // Reset during data bit 3 of a frame, then a clean 0x5A frame
      factor = 5'd16;
      rx_l[0] = 1'b0; hold(16);
      rx_l[0] = 1'b1; hold(16);
      rx_l[0] = 1'b1; hold(16);
      rx_l[0] = 1'b0; hold(16);
      rx_l[0] = 1'b0; hold(8);
      rst = 1'b0; rx_l[0] = 1'b1;
      repeat (3) @(negedge clk);
      lit("rst_busy", d_busy[0], 0);
      lit("rst_data", d_data[0], 0);
      lit("rst_valid", d_valid[0], 0);
      rst = 1'b1;
      hold(4);
      v0 = n_valid_w[0];
      send(0, 8'h5A, 16, 1'b0, 1'b0, 1'b1, -1, 5'd0);
      hold(6);
      lit("post_rst_data", e_data_w[0], 8'h5A);
      lit("post_rst_valid", n_valid_w[0] - v0, 1);

      // Randomized frames across instances, tick densities and factors
      for (int r = 0; r < 36; r++) begin
         tick_mode = $urandom_range(0, 3);
         if (tick_mode == 0) factor = 5'(fl_fast[$urandom_range(0, 5)]);
         else                factor = 5'(fl_slow[$urandom_range(0, 3)]);
         f = clampf(factor);
         i = $urandom_range(0, N - 1);
         d = 8'($urandom);
         pb = 1'($urandom);
         st = ($urandom_range(0, 7) != 0);
         pbad = (i == 0) ? 0 : ((($countones(d) + int'(pb)) % 2) != ((i == 2) ? 1 : 0)) ? 1 : 0;
         v0 = n_valid_w[i]; p0 = n_perr_w[i]; f0 = n_ferr_w[i];
         send(i, d, f, (i != 0), pb, st, -1, 5'd0);
         if (!st) begin
            hold($urandom_range(1, 20));
            rx_l[i] = 1'b1;
         end
         hold(6);
         if (st) begin
            lit($sformatf("rnd%0d_data", r), e_data_w[i], int'(d));
            lit($sformatf("rnd%0d_valid", r), n_valid_w[i] - v0, 1);
            lit($sformatf("rnd%0d_perr", r), n_perr_w[i] - p0, pbad);
         end else begin
            lit($sformatf("rnd%0d_ferr", r), n_ferr_w[i] - f0, 1);
            lit($sformatf("rnd%0d_novalid", r), n_valid_w[i] - v0, 0);
         end
      end

      hold(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
